// File: rtl/dram_timing_ctrl_if.sv
// Command/status bundle between the DRAM command FSM and its timing engine.
// The command FSM drives cmd_valid/cmd; the timing engine returns busy, done pulses and refresh status.
interface dram_timing_ctrl_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       busy;
    logic       init_done;
    logic       tACT_done;
    logic       tRD_done;
    logic       tWR_done;
    logic       tPRE_done;
    logic       tREF_done;
    logic       rf_req;
    logic       rf_overdue;
    logic       cmd_err;

    modport master (
        output cmd_valid, cmd,
        input  busy, init_done, tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done,
        input  rf_req, rf_overdue, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd,
        output busy, init_done, tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done,
        output rf_req, rf_overdue, cmd_err
    );
endinterface

// File: rtl/dram_timing_ctrl.sv
// Timing engine for the DRAM command FSM: power-up wait, per-command delays, refresh interval.
// One command in flight at a time; every delay is counted in clk cycles.
//
// state         | meaning
// --------------+-------------------------------------------------
// ST_INIT       | power-up wait, cnt_q counts up to T_INIT-1
// ST_IDLE       | ready, accepts ACT/RD/WR/PRE/REF
// ST_WAIT_ACT   | counting tRCD, cnt_q counts down to 0
// ST_WAIT_RD    | counting CL + burst
// ST_WAIT_WR    | counting burst + write recovery
// ST_WAIT_PRE   | counting tRP
// ST_WAIT_REF   | counting tRFC
module dram_timing_ctrl #(
    parameter int CNT_W     = 16,
    parameter int T_INIT    = 200,
    parameter int T_RCD     = 10,
    parameter int T_CL      = 10,
    parameter int T_WR      = 12,
    parameter int T_RP      = 10,
    parameter int T_RFC     = 260,
    parameter int T_REFI    = 6240,
    parameter int BURST_LEN = 4
) (
    input logic                 CLK,
    input logic                 RST,
    dram_timing_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT_ACT,
        ST_WAIT_RD,
        ST_WAIT_WR,
        ST_WAIT_PRE,
        ST_WAIT_REF
    } state_t;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    // Wait counters are loaded with N-1 so the done pulse lands exactly N edges after acceptance.
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT - 1);
    localparam logic [CNT_W-1:0] LD_ACT    = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RD     = CNT_W'(T_CL + BURST_LEN - 1);
    localparam logic [CNT_W-1:0] LD_WR     = CNT_W'(T_WR + BURST_LEN - 1);
    localparam logic [CNT_W-1:0] LD_PRE    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_REF    = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] ref_cnt_q,    ref_cnt_d;
    logic             init_done_q,  init_done_d;
    logic             act_done_q,   act_done_d;
    logic             rd_done_q,    rd_done_d;
    logic             wr_done_q,    wr_done_d;
    logic             pre_done_q,   pre_done_d;
    logic             ref_done_q,   ref_done_d;
    logic             rf_req_q,     rf_req_d;
    logic             rf_overdue_q, rf_overdue_d;
    logic             cmd_err_q,    cmd_err_d;

    logic in_wait;
    logic cmd_rsvd;
    logic ref_acc;
    logic ref_wrap;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            ref_cnt_q    <= '0;
            init_done_q  <= 1'b0;
            act_done_q   <= 1'b0;
            rd_done_q    <= 1'b0;
            wr_done_q    <= 1'b0;
            pre_done_q   <= 1'b0;
            ref_done_q   <= 1'b0;
            rf_req_q     <= 1'b0;
            rf_overdue_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ref_cnt_q    <= ref_cnt_d;
            init_done_q  <= init_done_d;
            act_done_q   <= act_done_d;
            rd_done_q    <= rd_done_d;
            wr_done_q    <= wr_done_d;
            pre_done_q   <= pre_done_d;
            ref_done_q   <= ref_done_d;
            rf_req_q     <= rf_req_d;
            rf_overdue_q <= rf_overdue_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        act_done_d  = 1'b0;
        rd_done_d   = 1'b0;
        wr_done_d   = 1'b0;
        pre_done_d  = 1'b0;
        ref_done_d  = 1'b0;
        cmd_err_d   = 1'b0;

        in_wait  = (state_q != ST_INIT) && (state_q != ST_IDLE);
        cmd_rsvd = (bus.cmd > CMD_REF);
        ref_acc  = (state_q == ST_IDLE) && bus.cmd_valid && (bus.cmd == CMD_REF);

        // Rejected commands never disturb the state or counters.
        if (bus.cmd_valid &&
            (cmd_rsvd || (state_q == ST_INIT) || (in_wait && (bus.cmd != CMD_NOP)))) begin
            cmd_err_d = 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd)
                        CMD_ACT: begin state_d = ST_WAIT_ACT; cnt_d = LD_ACT; end
                        CMD_RD:  begin state_d = ST_WAIT_RD;  cnt_d = LD_RD;  end
                        CMD_WR:  begin state_d = ST_WAIT_WR;  cnt_d = LD_WR;  end
                        CMD_PRE: begin state_d = ST_WAIT_PRE; cnt_d = LD_PRE; end
                        CMD_REF: begin state_d = ST_WAIT_REF; cnt_d = LD_REF; end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    case (state_q)
                        ST_WAIT_ACT: act_done_d = 1'b1;
                        ST_WAIT_RD:  rd_done_d  = 1'b1;
                        ST_WAIT_WR:  wr_done_d  = 1'b1;
                        ST_WAIT_PRE: pre_done_d = 1'b1;
                        ST_WAIT_REF: ref_done_d = 1'b1;
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // Refresh interval is free-running once init completes; a wrap beats a same-edge REF clear.
    always_comb begin
        ref_wrap  = init_done_q && (ref_cnt_q == REFI_LAST);
        ref_cnt_d = ref_cnt_q;
        if (init_done_q) begin
            ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        end

        rf_req_d = rf_req_q;
        if (ref_wrap) begin
            rf_req_d = 1'b1;
        end else if (ref_acc) begin
            rf_req_d = 1'b0;
        end
        rf_overdue_d = ref_wrap && rf_req_q;
    end

    assign bus.busy       = (state_q != ST_INIT) && (state_q != ST_IDLE);
    assign bus.init_done  = init_done_q;
    assign bus.tACT_done  = act_done_q;
    assign bus.tRD_done   = rd_done_q;
    assign bus.tWR_done   = wr_done_q;
    assign bus.tPRE_done  = pre_done_q;
    assign bus.tREF_done  = ref_done_q;
    assign bus.rf_req     = rf_req_q;
    assign bus.rf_overdue = rf_overdue_q;
    assign bus.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Directed bench for dram_timing_ctrl: default-parameter instance plus a short-interval instance.
module tb_dram_timing_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic rst_s = 1'b1;

    always #5 CLK = ~CLK;

    dram_timing_ctrl_if bus ();
    dram_timing_ctrl_if bus_s ();

    dram_timing_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    dram_timing_ctrl #(
        .T_INIT (8),
        .T_RFC  (5),
        .T_REFI (20)
    ) dut_s (
        .CLK (CLK),
        .RST (rst_s),
        .bus (bus_s)
    );

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   t_init, t_wrap, k, t2;
    logic wr_seen, ref_seen;

    task automatic tick;
        @(posedge CLK);
        #1;
        edge_n++;
        if (bus.tWR_done)  wr_seen  = 1'b1;
        if (bus.tREF_done) ref_seen = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] outs_main();
        return {bus.busy, bus.init_done, bus.tACT_done, bus.tRD_done, bus.tWR_done,
                bus.tPRE_done, bus.tREF_done, bus.rf_req, bus.rf_overdue, bus.cmd_err};
    endfunction

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd         = 3'd0;
        bus_s.cmd_valid = 1'b0;
        bus_s.cmd       = 3'd0;
        wr_seen         = 1'b0;
        ref_seen        = 1'b0;

        // Reset held for three edges
        tick;
        check("reset_outputs", 32'(outs_main()), 32'h0);
        tick;
        tick;
        RST = 1'b0;

        // Init wait with a command attempted during INIT
        repeat (10) tick;
        bus.cmd_valid = 1'b1; bus.cmd = 3'd1;
        tick;
        check("init_cmd_err", 32'(bus.cmd_err), 32'h1);
        check("init_cmd_busy", 32'(bus.busy), 32'h0);
        bus.cmd_valid = 1'b0;
        tick;
        check("init_cmd_err_clear", 32'(bus.cmd_err), 32'h0);
        repeat (187) tick;
        check("init_done_199", 32'(bus.init_done), 32'h0);
        tick;
        check("init_done_200", 32'(bus.init_done), 32'h1);
        check("idle_busy", 32'(bus.busy), 32'h0);
        t_init = edge_n;

        // NOP ignored, reserved code rejected
        bus.cmd_valid = 1'b1; bus.cmd = 3'd0;
        tick;
        check("nop_no_err", 32'(bus.cmd_err), 32'h0);
        check("nop_no_busy", 32'(bus.busy), 32'h0);
        bus.cmd = 3'd6;
        tick;
        check("rsvd_err", 32'(bus.cmd_err), 32'h1);
        check("rsvd_no_busy", 32'(bus.busy), 32'h0);
        bus.cmd_valid = 1'b0;
        tick;

        // ACT then RD back-to-back
        bus.cmd_valid = 1'b1; bus.cmd = 3'd1;
        tick;
        check("act_busy_k", 32'(bus.busy), 32'h1);
        bus.cmd_valid = 1'b0;
        repeat (9) tick;
        check("act_done_k9", 32'(bus.tACT_done), 32'h0);
        check("act_busy_k9", 32'(bus.busy), 32'h1);
        tick;
        check("act_done_k10", 32'(bus.tACT_done), 32'h1);
        check("act_busy_k10", 32'(bus.busy), 32'h0);
        bus.cmd_valid = 1'b1; bus.cmd = 3'd2;
        tick;
        check("rd_busy_k11", 32'(bus.busy), 32'h1);
        check("act_done_k11", 32'(bus.tACT_done), 32'h0);
        bus.cmd_valid = 1'b0;
        repeat (13) tick;
        check("rd_done_k24", 32'(bus.tRD_done), 32'h0);
        tick;
        check("rd_done_k25", 32'(bus.tRD_done), 32'h1);
        check("rd_busy_k25", 32'(bus.busy), 32'h0);
        tick;
        check("rd_done_k26", 32'(bus.tRD_done), 32'h0);

        // WR presented while ACT in flight
        wr_seen = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd = 3'd1;
        tick;
        bus.cmd_valid = 1'b0;
        repeat (3) tick;
        bus.cmd_valid = 1'b1; bus.cmd = 3'd3;
        tick;
        check("wr_busy_err", 32'(bus.cmd_err), 32'h1);
        check("wr_busy_busy", 32'(bus.busy), 32'h1);
        bus.cmd_valid = 1'b0;
        repeat (5) tick;
        check("act2_done_k9", 32'(bus.tACT_done), 32'h0);
        tick;
        check("act2_done_k10", 32'(bus.tACT_done), 32'h1);
        repeat (20) tick;
        check("wr_never_done", 32'(wr_seen), 32'h0);

        // WR and PRE durations
        bus.cmd_valid = 1'b1; bus.cmd = 3'd3;
        tick;
        bus.cmd_valid = 1'b0;
        repeat (15) tick;
        check("wr_done_15", 32'(bus.tWR_done), 32'h0);
        tick;
        check("wr_done_16", 32'(bus.tWR_done), 32'h1);
        bus.cmd_valid = 1'b1; bus.cmd = 3'd4;
        tick;
        bus.cmd_valid = 1'b0;
        repeat (9) tick;
        check("pre_done_9", 32'(bus.tPRE_done), 32'h0);
        tick;
        check("pre_done_10", 32'(bus.tPRE_done), 32'h1);

        // Refresh interval and REF
        while (edge_n < t_init + 6239) tick;
        check("rf_req_6239", 32'(bus.rf_req), 32'h0);
        tick;
        check("rf_req_6240", 32'(bus.rf_req), 32'h1);
        check("rf_overdue_first", 32'(bus.rf_overdue), 32'h0);
        t_wrap = edge_n;
        repeat (4) tick;
        bus.cmd_valid = 1'b1; bus.cmd = 3'd5;
        tick;
        check("ref_clears_req", 32'(bus.rf_req), 32'h0);
        check("ref_busy", 32'(bus.busy), 32'h1);
        k = edge_n;
        bus.cmd_valid = 1'b0;
        while (edge_n < k + 259) tick;
        check("ref_done_259", 32'(bus.tREF_done), 32'h0);
        tick;
        check("ref_done_260", 32'(bus.tREF_done), 32'h1);
        while (edge_n < t_wrap + 6239) tick;
        check("rf_req2_6239", 32'(bus.rf_req), 32'h0);
        tick;
        check("rf_req2_6240", 32'(bus.rf_req), 32'h1);
        check("rf_overdue2", 32'(bus.rf_overdue), 32'h0);

        // Reset in the middle of a REF wait
        bus.cmd_valid = 1'b1; bus.cmd = 3'd5;
        tick;
        check("ref2_busy", 32'(bus.busy), 32'h1);
        bus.cmd_valid = 1'b0;
        ref_seen = 1'b0;
        repeat (49) tick;
        RST = 1'b1;
        tick;
        check("midrst_outputs", 32'(outs_main()), 32'h0);
        tick;
        RST = 1'b0;
        repeat (199) tick;
        check("reinit_199", 32'(bus.init_done), 32'h0);
        tick;
        check("reinit_200", 32'(bus.init_done), 32'h1);
        repeat (20) tick;
        check("midrst_no_ref_done", 32'(ref_seen), 32'h0);

        // Short-interval instance: overdue and coincident wrap/REF
        rst_s = 1'b0;
        repeat (7) tick;
        check("s_init_7", 32'(bus_s.init_done), 32'h0);
        tick;
        check("s_init_8", 32'(bus_s.init_done), 32'h1);
        t2 = edge_n;
        while (edge_n < t2 + 20) tick;
        check("s_rf_req_w1", 32'(bus_s.rf_req), 32'h1);
        check("s_overdue_w1", 32'(bus_s.rf_overdue), 32'h0);
        while (edge_n < t2 + 40) tick;
        check("s_overdue_w2", 32'(bus_s.rf_overdue), 32'h1);
        tick;
        check("s_overdue_w2p1", 32'(bus_s.rf_overdue), 32'h0);
        while (edge_n < t2 + 60) tick;
        check("s_overdue_w3", 32'(bus_s.rf_overdue), 32'h1);
        while (edge_n < t2 + 79) tick;
        bus_s.cmd_valid = 1'b1; bus_s.cmd = 3'd5;
        tick;
        check("s_coinc_req", 32'(bus_s.rf_req), 32'h1);
        check("s_coinc_busy", 32'(bus_s.busy), 32'h1);
        check("s_coinc_overdue", 32'(bus_s.rf_overdue), 32'h1);
        bus_s.cmd_valid = 1'b0;
        while (edge_n < t2 + 90) tick;
        bus_s.cmd_valid = 1'b1; bus_s.cmd = 3'd5;
        tick;
        check("s_ref_clear", 32'(bus_s.rf_req), 32'h0);
        bus_s.cmd_valid = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
